// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared memory port of the multicycle MIPS core.
// One transaction in flight; the CPU has priority, but a starvation counter guarantees the loader a grant.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          cclk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] SMAX  = 4'(MAX_WAIT);
  localparam logic [1:0] WLAST = 2'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dbg_ready_q, dbg_ready_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          grant_dbg;

  // Loader wins when alone, or when it has watched MAX_WAIT CPU grants in a row.
  assign grant_dbg = dbg_req & (~cpu_req | (starve_q == SMAX));

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cpu_req | dbg_req) state_d = ACCESS;
      ACCESS: state_d = mem_we_q ? RESP : WAIT;
      WAIT:   if (wcnt_q == WLAST) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d    = starve_q;
    wcnt_d      = wcnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (!dbg_req) starve_d = 4'd0;
        if (cpu_req | dbg_req) begin
          mem_en_d = 1'b1;
          owner_d  = grant_dbg;
          if (grant_dbg) begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            starve_d    = 4'd0;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            if (dbg_req && starve_q != SMAX) starve_d = starve_q + 4'd1;
          end
        end
      end
      ACCESS: begin
        wcnt_d = 2'd0;
        if (mem_we_q) begin
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 2'd1;
        // Final wait cycle: memory data is valid now, hand it to the owner only.
        if (wcnt_q == WLAST) begin
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      starve_q    <= 4'd0;
      wcnt_q      <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      wcnt_q      <= wcnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus contention, tie-break and reset sequences.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, RD_LAT = 2, MAX_WAIT = 4;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic          cclk = 1'b0, rst = 1'b1;
  logic          cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0, mem_addr;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0, mem_wdata, mem_rdata = JUNK;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          cpu_ready, dbg_ready, mem_en, mem_we, owner, busy;

  int total = 0, bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .cclk(cclk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    bit          port;   // 0=CPU 1=loader
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;    // data memory presents on the capture cycle
    logic [31:0] exp_crd;
    logic [31:0] exp_drd;
  } vec_t;

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, ".ctl"}, {26'd0, mem_en, mem_we, cpu_ready, dbg_ready, owner, busy}, 32'd0);
    chk({nm, ".addr"}, mem_addr | mem_wdata, 32'd0);
    chk({nm, ".rdata"}, cpu_rdata | dbg_rdata, 32'd0);
  endtask

  // Drive one request, check cycle-exact memory strobe, wait states and ready pulse.
  task automatic do_txn(input vec_t v);
    if (v.port) begin
      dbg_req = 1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    step();
    chk("acc.mem_en", {31'd0, mem_en}, 32'd1);
    chk("acc.mem_we", {31'd0, mem_we}, {31'd0, v.we});
    chk("acc.mem_addr", mem_addr, v.addr);
    if (v.we) chk("acc.mem_wdata", mem_wdata, v.wdata);
    chk("acc.owner", {31'd0, owner}, {31'd0, v.port});
    chk("acc.busy", {31'd0, busy}, 32'd1);
    // Fields move after the grant; the latched transaction must not follow them.
    if (v.port) begin dbg_addr = ~v.addr; dbg_wdata = ~v.wdata; end
    else        begin cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; end
    if (!v.we) begin
      for (int i = 0; i < RD_LAT; i++) begin
        step();
        chk("wait.en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("wait.ready", {30'd0, cpu_ready, dbg_ready}, 32'd0);
        chk("wait.mem_addr", mem_addr, v.addr);
        if (i == RD_LAT - 1) mem_rdata = v.mrd;
      end
    end
    step();
    mem_rdata = JUNK;
    chk("resp.ready", {30'd0, cpu_ready, dbg_ready}, v.port ? 32'd1 : 32'd2);
    chk("resp.mem_en", {31'd0, mem_en}, 32'd0);
    chk("resp.cpu_rdata", cpu_rdata, v.exp_crd);
    chk("resp.dbg_rdata", dbg_rdata, v.exp_drd);
    cpu_req = 0; dbg_req = 0;
    step();
    chk("idle.busy_ready", {29'd0, busy, cpu_ready, dbg_ready}, 32'd0);
    chk("idle.cpu_rdata", cpu_rdata, v.exp_crd);
    chk("idle.dbg_rdata", dbg_rdata, v.exp_drd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    logic [31:0] grants [6];
    logic [31:0] exp_g  [6];
    int n, cyc;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, JUNK,         32'h0,         32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, JUNK,         32'hCAFE_F00D, 32'h1234_5678};
    tbl[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, JUNK,         32'hCAFE_F00D, 32'h1234_5678};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         32'hCAFE_F00D, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

    // Reset, then ten idle cycles with everything low.
    step(); step();
    chk_zero_outputs("reset");
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_zero_outputs("idle10");
    end

    foreach (tbl[i]) do_txn(tbl[i]);

    // Contention: both held high, writes, grant order CPU x4 then loader.
    exp_g = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
    cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = 32'h1;
    dbg_we = 1; dbg_addr = 32'h400; dbg_wdata = 32'h2;
    cpu_req = 1; dbg_req = 1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 80) begin
      step(); cyc++;
      if (mem_en) begin grants[n] = {31'd0, owner}; n++; end
    end
    chk("contend.count", n, 6);
    for (int i = 0; i < 6 && i < n; i++) chk($sformatf("contend.grant%0d", i), grants[i], exp_g[i]);
    cpu_req = 0; dbg_req = 0;
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    chk("contend.drain", {31'd0, busy}, 32'd0);
    step();

    // Simultaneous requests with an empty counter: CPU first, loader right after CPU's RESP.
    cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h11;
    dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h22;
    cpu_req = 1; dbg_req = 1;
    step();
    chk("tie.acc_cpu", {mem_en, owner, mem_addr[29:0]}, {1'b1, 1'b0, 30'h10});
    step();
    chk("tie.cpu_ready", {30'd0, cpu_ready, dbg_ready}, 32'd2);
    cpu_req = 0;
    step();
    chk("tie.idle_gap", {30'd0, mem_en, busy}, 32'd0);
    step();
    chk("tie.acc_dbg", {mem_en, owner, mem_addr[29:0]}, {1'b1, 1'b1, 30'h20});
    chk("tie.dbg_wdata", mem_wdata, 32'h22);
    step();
    chk("tie.dbg_ready", {30'd0, cpu_ready, dbg_ready}, 32'd1);
    dbg_req = 0;
    step();

    // Reset in the WAIT state of a CPU read: access dropped, no ready pulse.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
    step();
    chk("rstw.acc", {31'd0, mem_en}, 32'd1);
    step();
    #2 rst = 1;
    #1;
    chk_zero_outputs("rstw.async");
    cpu_req = 0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_ready) n++;
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_ready | mem_en) n++;
    end
    chk("rstw.no_ready", n, 0);
    rv = '{1'b0, 1'b0, 32'h80, 32'h0, 32'h7777_1234, 32'h7777_1234, 32'h0};
    do_txn(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared memory port of the multicycle MIPS core between two requesters.
- Requester 0 is the CPU, driven by the control unit's IorD/MemWrite access phases. Requester 1 is the debug/program loader.
- One transaction in flight at a time: fixed CPU priority, with a starvation counter that guarantees the loader a grant.
- All memory-side outputs are registered; read data is returned per requester with a one-cycle ready pulse.

Parameters:
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4
- MAX_WAIT, 4, consecutive CPU grants allowed while loader is waiting before the loader is forced to win; legal range 1..15

Ports:
- cclk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid from cpu_ready onward
- cpu_ready  out  1  one-cycle completion pulse to CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ready: same widths and meanings for the loader
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, only ever high with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- owner  out  1  0=CPU, 1=loader; owner of the current or last transaction
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, starvation count=0.
  - mem_en, mem_we, mem_addr, mem_wdata, cpu_ready, dbg_ready, cpu_rdata, dbg_rdata, owner, busy all 0.
  - Reset mid-transaction drops the access with no ready pulse; the requester must reissue.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata into the mem_* registers and owner, then go to ACCESS.
- Arbitration:
  - Only cpu_req: CPU wins. Only dbg_req: loader wins.
  - Both requesting: CPU wins unless count==MAX_WAIT, in which case the loader wins.
- Starvation count:
  - +1 on each CPU grant made while dbg_req=1, saturating at MAX_WAIT.
  - Cleared on a loader grant, or in any IDLE cycle with dbg_req=0.
- ACCESS:
  - mem_en=1 for exactly one cycle; mem_we=latched we.
  - Write: go to RESP. Read: go to WAIT.
- WAIT:
  - Held for exactly RD_LAT cycles; mem_en=0.
  - On the final WAIT cycle edge, capture mem_rdata into the owner's rdata register.
  - The other requester's rdata is never modified.
- RESP:
  - Owner's ready=1 for one cycle, then return to IDLE.
  - The other requester's ready stays 0.
- Latency, with request first seen in IDLE at cycle T:
  - Write: mem_en at T+1, ready at T+2.
  - Read: mem_en at T+1, ready at T+2+RD_LAT (RD_LAT=1 gives T+3).
- Back-to-back:
  - A requester still asserting req in the IDLE cycle after RESP is treated as a new request.
  - Minimum gap between successive mem_en pulses is 3 cycles (write) or 3+RD_LAT cycles (read).
- Request changes:
  - Requests that drop before a grant are ignored.
  - Changes to request fields after the grant have no effect on the current transaction.
- mem_addr/mem_wdata hold their last values between transactions; mem_we is cleared whenever mem_en=0.
- rdata outputs hold until that port's next read completes.

Test Plan:
- Reset then idle 10 cycles: all outputs 0, busy=0, no mem_en.
- CPU write: cpu_req=1, we=1, addr=0x40, wdata=0xDEADBEEF at T. Required: mem_en=mem_we=1 with addr 0x40 / data 0xDEADBEEF at T+1; cpu_ready at T+2; dbg_ready=0 throughout.
- Loader read, RD_LAT=2: memory returns 0x12345678 in cycle T+3. Required: dbg_rdata=0x12345678 and dbg_ready=1 at T+4; cpu_rdata unchanged.
- Contention, MAX_WAIT=4, both requesters held high continuously: grant order CPU,CPU,CPU,CPU,DBG,CPU...; owner sequence 0,0,0,0,1,0.
- Same-cycle requests with count=0: CPU wins; loader is granted in the IDLE cycle directly after the CPU's RESP if the CPU drops cpu_req.
- rst asserted during WAIT of a CPU read: outputs return to 0 immediately; no cpu_ready; the next CPU request completes normally with correct latency.
